// File: rtl/four_bit_serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor slice.
package sub_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_state_e;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/four_bit_serial_subtractor_if.sv
// Operand/result handshake bundle for four_bit_serial_subtractor.
// The ovf signal exists only when SUB_OVERFLOW_EN is defined.
interface four_bit_serial_subtractor_if
  import sub_pkg::*;
  #(parameter int WIDTH = DEFAULT_WIDTH) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             out_valid;
  logic             out_ready;
`ifdef SUB_OVERFLOW_EN
  logic             ovf;

  modport master (output a, b, bin, in_valid, out_ready,
                  input  in_ready, diff, bout, out_valid, ovf);
  modport slave  (input  a, b, bin, in_valid, out_ready,
                  output in_ready, diff, bout, out_valid, ovf);
`else
  modport master (output a, b, bin, in_valid, out_ready,
                  input  in_ready, diff, bout, out_valid);
  modport slave  (input  a, b, bin, in_valid, out_ready,
                  output in_ready, diff, bout, out_valid);
`endif

endinterface

// File: rtl/four_bit_serial_subtractor_cell.sv
// Combinational 1-bit full subtractor, reused serially by the top.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial subtractor: {bout,diff} = a - b - bin, one bit per BUSY cycle.
// Optional signed-overflow output enabled by defining SUB_OVERFLOW_EN.
module four_bit_serial_subtractor
  import sub_pkg::*;
  #(parameter int WIDTH = DEFAULT_WIDTH) (
  input  logic                    clk,
  input  logic                    rst_n,
  four_bit_serial_subtractor_if.slave bus
);

  localparam int IW = idx_width(WIDTH);

  sub_state_e       state;
  sub_state_e       state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_q;
  logic [IW-1:0]    idx;
  logic             br;
  logic             bout_q;
  logic             tail;
  logic             last_bit;
  logic             cell_d;
  logic             cell_bout;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_q;
`endif

  full_subtractor_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (idx == IW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // tail adds one settle cycle after the MSB so the result appears WIDTH+1 edges after accept
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = BUSY;
      BUSY:    if (tail)          state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      diff_q <= '0;
      idx    <= '0;
      br     <= 1'b0;
      bout_q <= 1'b0;
      tail   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            br   <= bus.bin;
            idx  <= '0;
            tail <= 1'b0;
          end
        end
        BUSY: begin
          if (!tail) begin
            diff_q <= {cell_d, diff_q[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            br     <= cell_bout;
            idx    <= idx + IW'(1);
            if (last_bit) begin
              bout_q <= cell_bout;
              tail   <= 1'b1;
`ifdef SUB_OVERFLOW_EN
              // borrow into the MSB differs from borrow out of it on signed overflow
              ovf_q  <= br ^ cell_bout;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule
